// File: rtl/ntt_bfly_sched_if.sv
// Bundle between the NTT butterfly sequencer and its controller / memory.
// The sequencer side takes "master", since it drives the memory address buses.
interface ntt_bfly_sched_if #(
  parameter int LOGN = 12
);
  localparam int STW = (LOGN > 2) ? $clog2(LOGN) : 1;

  logic            start_i;
  logic            en_i;
  logic            busy_o;
  logic            done_o;
  logic [STW-1:0]  stage_o;
  logic            rd_valid_o;
  logic [LOGN-1:0] rd_addr_a_o;
  logic [LOGN-1:0] rd_addr_b_o;
  logic [LOGN-2:0] tw_idx_o;
  logic            wr_valid_o;
  logic [LOGN-1:0] wr_addr_a_o;
  logic [LOGN-1:0] wr_addr_b_o;

  modport master (
    input  start_i, en_i,
    output busy_o, done_o, stage_o,
    output rd_valid_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
    output wr_valid_o, wr_addr_a_o, wr_addr_b_o
  );

  modport slave (
    output start_i, en_i,
    input  busy_o, done_o, stage_o,
    input  rd_valid_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
    input  wr_valid_o, wr_addr_a_o, wr_addr_b_o
  );
endinterface

// File: rtl/ntt_bfly_sched.sv
// Stage/address sequencer for a radix-2 Gentleman-Sande NTT butterfly pipe.
// Issues one read pair + twiddle index per enabled cycle, replays the pair as
// a write-back exactly LAT cycles later, and drains between stages so a stage
// never reads data the previous stage has not yet written back.
module ntt_bfly_sched #(
  parameter int LOGN = 12,
  parameter int LAT  = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ntt_bfly_sched_if.master  bus
);
  localparam int STW = (LOGN > 2) ? $clog2(LOGN) : 1;
  localparam int CW  = $clog2(LAT + 1);
  localparam int KW  = LOGN - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [STW-1:0]  stage_q, stage_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            done_q, done_d;
  logic [LAT-1:0]  pv_q, pv_d;
  logic [LOGN-1:0] pa_q [LAT];
  logic [LOGN-1:0] pa_d [LAT];
  logic [LOGN-1:0] pb_q [LAT];
  logic [LOGN-1:0] pb_d [LAT];

  logic            rd_valid;
  logic            wr_valid;
  logic            drained;
  logic [LOGN-1:0] half;
  logic [LOGN-1:0] mask;
  logic [LOGN-1:0] k_ext;
  logic [LOGN-1:0] addr_a;
  logic [LOGN-1:0] addr_b;
  logic [KW-1:0]   tw;

  assign rd_valid = (state_q == ISSUE) && bus.en_i;
  assign wr_valid = pv_q[LAT-1];
  assign drained  = (inflight_q == '0) && !wr_valid;

  // Pair addressing: a is k with a zero inserted at bit (LOGN-1-s), b sets that bit.
  always_comb begin
    half   = {1'b1, {(LOGN-1){1'b0}}} >> stage_q;
    mask   = half - LOGN'(1);
    k_ext  = {1'b0, k_q};
    addr_a = ((k_ext & ~mask) << 1) | (k_ext & mask);
    addr_b = addr_a | half;
    tw     = (k_q & mask[KW-1:0]) << stage_q;
    if (state_q == IDLE) begin
      addr_a = '0;
      addr_b = '0;
      tw     = '0;
    end
  end

  // Next-state logic: stage/pair walk, drain handshake and done pulse.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (rd_valid) begin
          k_d = k_q + KW'(1);
          if (&k_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          k_d = '0;
          if (stage_q == STW'(LOGN - 1)) begin
            state_d = IDLE;
            stage_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + STW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-flight count and the LAT-deep read-to-write replay pipe.
  always_comb begin
    inflight_d = inflight_q;
    case ({rd_valid, wr_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    pv_d[0] = rd_valid;
    pa_d[0] = rd_valid ? addr_a : '0;
    pb_d[0] = rd_valid ? addr_b : '0;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pb_d[i] = pb_q[i-1];
    end
  end

  // State registers; reset also discards every pending write-back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      k_q        <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      pv_q       <= '0;
      for (int i = 0; i < LAT; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      k_q        <= k_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      pv_q       <= pv_d;
      for (int i = 0; i < LAT; i++) begin
        pa_q[i] <= pa_d[i];
        pb_q[i] <= pb_d[i];
      end
    end
  end

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done_q;
  assign bus.stage_o     = stage_q;
  assign bus.rd_valid_o  = rd_valid;
  assign bus.rd_addr_a_o = addr_a;
  assign bus.rd_addr_b_o = addr_b;
  assign bus.tw_idx_o    = tw;
  assign bus.wr_valid_o  = wr_valid;
  assign bus.wr_addr_a_o = pa_q[LAT-1];
  assign bus.wr_addr_b_o = pb_q[LAT-1];
endmodule

// File: tb/tb_ntt_bfly_sched.sv
// Bench for ntt_bfly_sched: a small LOGN=3/LAT=4 instance for directed timing
// scenarios and a LOGN=12/LAT=10 instance driven with random issue enables.
// Reads push their expected write-back onto a queue; writes pop and compare.
module tb_ntt_bfly_sched;
  localparam int S_LOGN = 3;
  localparam int S_LAT  = 4;
  localparam int B_LOGN = 12;
  localparam int B_LAT  = 10;
  localparam int B_N    = 1 << B_LOGN;

  typedef struct {
    int a;
    int b;
    int s;
    int c;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   t0 = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  pend_t sq[$];
  pend_t bq[$];

  int sm_s = 0, sm_k = 0, s_nrd = 0, s_nwr = 0, s_ndone = 0;
  int bm_s = 0, bm_k = 0, b_nrd = 0, b_nwr = 0, b_ndone = 0, bw_cnt = 0;
  logic [B_N-1:0] bw = '0;

  ntt_bfly_sched_if #(.LOGN(S_LOGN)) s_if();
  ntt_bfly_sched_if #(.LOGN(B_LOGN)) b_if();

  ntt_bfly_sched #(.LOGN(S_LOGN), .LAT(S_LAT)) u_small (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (s_if.master)
  );

  ntt_bfly_sched #(.LOGN(B_LOGN), .LAT(B_LAT)) u_big (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b_if.master)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference pair from the DIF formula: a = g*2*half + j, b = a + half.
  function automatic void exp_pair(input int logn, input int s, input int k,
                                   output int a, output int b, output int tw, output int half);
    int sh, g, j;
    sh   = logn - 1 - s;
    half = 1 << sh;
    g    = k >> sh;
    j    = k & (half - 1);
    a    = g * 2 * half + j;
    b    = a + half;
    tw   = (j << s) & ((1 << (logn - 1)) - 1);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_at(input int n);
    while (cyc < t0 + n) next_cycle();
  endtask

  task automatic sample_at(input int n);
    drive_at(n);
    @(negedge clk);
  endtask

  task automatic apply_stimulus();
    next_cycle();
    t0      = cyc;
    s_nrd   = 0;
    s_nwr   = 0;
    s_ndone = 0;
    s_if.start_i = 1'b1;
  endtask

  task automatic check_output(input string tag, input logic [2:0] a, input logic [2:0] b, input logic [1:0] tw);
    check({tag, "_rd_valid"}, s_if.rd_valid_o, 1);
    check({tag, "_rd_a"}, s_if.rd_addr_a_o, a);
    check({tag, "_rd_b"}, s_if.rd_addr_b_o, b);
    check({tag, "_tw"}, s_if.tw_idx_o, tw);
  endtask

  // Full LOGN=3/LAT=4 run with en_i high; start_i optionally left high throughout.
  task automatic nominal_checks(input bit held);
    sample_at(0);
    check("c0_busy", s_if.busy_o, 0);
    if (!held) begin
      drive_at(1);
      s_if.start_i = 1'b0;
    end
    sample_at(1);
    check("c1_busy", s_if.busy_o, 1);
    check("c1_stage", s_if.stage_o, 0);
    check_output("c1", 3'd0, 3'd4, 2'd0);
    sample_at(4);
    check_output("c4", 3'd3, 3'd7, 2'd3);
    sample_at(5);
    check("c5_rd_valid", s_if.rd_valid_o, 0);
    check("c5_wr_valid", s_if.wr_valid_o, 1);
    check("c5_wr_a", s_if.wr_addr_a_o, 0);
    check("c5_wr_b", s_if.wr_addr_b_o, 4);
    sample_at(8);
    check("c8_wr_a", s_if.wr_addr_a_o, 3);
    check("c8_wr_b", s_if.wr_addr_b_o, 7);
    sample_at(9);
    check("c9_rd_valid", s_if.rd_valid_o, 0);
    check("c9_wr_valid", s_if.wr_valid_o, 0);
    check("c9_busy", s_if.busy_o, 1);
    sample_at(10);
    check("c10_stage", s_if.stage_o, 1);
    check_output("c10", 3'd0, 3'd2, 2'd0);
    sample_at(11);
    check_output("c11", 3'd1, 3'd3, 2'd2);
    sample_at(12);
    check_output("c12", 3'd4, 3'd6, 2'd0);
    sample_at(18);
    check("c18_rd_valid", s_if.rd_valid_o, 0);
    check("c18_stage", s_if.stage_o, 1);
    sample_at(19);
    check("c19_stage", s_if.stage_o, 2);
    check_output("c19", 3'd0, 3'd1, 2'd0);
    sample_at(22);
    check_output("c22", 3'd6, 3'd7, 2'd0);
    sample_at(27);
    check("c27_busy", s_if.busy_o, 1);
    check("c27_done", s_if.done_o, 0);
    sample_at(28);
    check("c28_done", s_if.done_o, 1);
    check("c28_busy", s_if.busy_o, 0);
    check("c28_stage", s_if.stage_o, 0);
    check("c28_rd_a", s_if.rd_addr_a_o, 0);
  endtask

  // Scoreboard for the small instance.
  always @(negedge clk) begin : mon_small
    pend_t e;
    int a, b, tw, half;
    if (!rst_n) begin
      sq.delete();
      sm_s = 0;
      sm_k = 0;
    end else begin
      if (s_if.wr_valid_o) begin
        check("s_wr_pending", sq.size() != 0, 1);
        if (sq.size() != 0) begin
          e = sq.pop_front();
          check("s_wr_a", s_if.wr_addr_a_o, e.a);
          check("s_wr_b", s_if.wr_addr_b_o, e.b);
          check("s_wr_latency", cyc - e.c, S_LAT);
          s_nwr++;
        end
      end
      if (s_if.rd_valid_o) begin
        exp_pair(S_LOGN, sm_s, sm_k, a, b, tw, half);
        check("s_rd_a", s_if.rd_addr_a_o, a);
        check("s_rd_b", s_if.rd_addr_b_o, b);
        check("s_rd_tw", s_if.tw_idx_o, tw);
        check("s_rd_stage", s_if.stage_o, sm_s);
        if (sq.size() != 0) check("s_rd_stage_order", sq[0].s, sm_s);
        sq.push_back('{a, b, sm_s, cyc});
        s_nrd++;
        sm_k++;
        if (sm_k == (1 << (S_LOGN - 1))) begin
          sm_k = 0;
          sm_s++;
        end
      end
      if (s_if.done_o) begin
        check("s_done_stages", sm_s, S_LOGN);
        s_ndone++;
        sm_s = 0;
        sm_k = 0;
      end
    end
  end

  // Scoreboard for the large instance, with per-stage write-once bitmap.
  always @(negedge clk) begin : mon_big
    pend_t e;
    int a, b, tw, half;
    if (!rst_n) begin
      bq.delete();
      bm_s   = 0;
      bm_k   = 0;
      bw     = '0;
      bw_cnt = 0;
    end else begin
      if (b_if.wr_valid_o) begin
        check("b_wr_pending", bq.size() != 0, 1);
        if (bq.size() != 0) begin
          e = bq.pop_front();
          check("b_wr_a", b_if.wr_addr_a_o, e.a);
          check("b_wr_b", b_if.wr_addr_b_o, e.b);
          check("b_wr_latency", cyc - e.c, B_LAT);
          check("b_wr_once", {bw[b_if.wr_addr_a_o], bw[b_if.wr_addr_b_o]}, 0);
          bw[b_if.wr_addr_a_o] = 1'b1;
          bw[b_if.wr_addr_b_o] = 1'b1;
          bw_cnt += 2;
          b_nwr++;
        end
      end
      if (b_if.rd_valid_o) begin
        if (bm_k == 0 && bm_s > 0) begin
          check("b_prev_stage_written", bw_cnt, B_N);
          check("b_no_early_read", bq.size(), 0);
          bw     = '0;
          bw_cnt = 0;
        end
        exp_pair(B_LOGN, bm_s, bm_k, a, b, tw, half);
        check("b_rd_a", b_if.rd_addr_a_o, a);
        check("b_rd_b", b_if.rd_addr_b_o, b);
        check("b_rd_tw", b_if.tw_idx_o, tw);
        check("b_rd_stage", b_if.stage_o, bm_s);
        check("b_pair_gap", int'(b_if.rd_addr_b_o) - int'(b_if.rd_addr_a_o), half);
        bq.push_back('{a, b, bm_s, cyc});
        b_nrd++;
        bm_k++;
        if (bm_k == (1 << (B_LOGN - 1))) begin
          bm_k = 0;
          bm_s++;
        end
      end
      if (b_if.done_o) begin
        check("b_done_stages", bm_s, B_LOGN);
        check("b_last_stage_written", bw_cnt, B_N);
        b_ndone++;
        bm_s   = 0;
        bm_k   = 0;
        bw     = '0;
        bw_cnt = 0;
      end
    end
  end

  // Directed scenario sequence followed by the randomised large transform.
  initial begin
    bit b_seen;
    rst_n        = 1'b0;
    s_if.start_i = 1'b0;
    s_if.en_i    = 1'b1;
    b_if.start_i = 1'b0;
    b_if.en_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", s_if.busy_o, 0);
    check("rst_done", s_if.done_o, 0);
    check("rst_rd_valid", s_if.rd_valid_o, 0);
    check("rst_wr_valid", s_if.wr_valid_o, 0);
    check("rst_stage", s_if.stage_o, 0);
    check("rst_big_busy", b_if.busy_o, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("[TB] nominal transform");
    apply_stimulus();
    nominal_checks(1'b0);
    sample_at(29);
    check("c29_done", s_if.done_o, 0);
    check("c29_busy", s_if.busy_o, 0);
    check("nom_reads", s_nrd, 12);
    check("nom_writes", s_nwr, 12);
    check("nom_dones", s_ndone, 1);

    $display("[TB] issue stalls");
    apply_stimulus();
    drive_at(1);
    s_if.start_i = 1'b0;
    drive_at(2);
    s_if.en_i = 1'b0;
    sample_at(2);
    check("st2_rd_valid", s_if.rd_valid_o, 0);
    check("st2_rd_a", s_if.rd_addr_a_o, 1);
    check("st2_rd_b", s_if.rd_addr_b_o, 5);
    sample_at(3);
    check("st3_rd_valid", s_if.rd_valid_o, 0);
    check("st3_rd_a", s_if.rd_addr_a_o, 1);
    drive_at(4);
    s_if.en_i = 1'b1;
    sample_at(4);
    check("st4_rd_valid", s_if.rd_valid_o, 1);
    check("st4_rd_a", s_if.rd_addr_a_o, 1);
    sample_at(5);
    check("st5_wr_a", s_if.wr_addr_a_o, 0);
    sample_at(6);
    check("st6_wr_valid", s_if.wr_valid_o, 0);
    sample_at(8);
    check("st8_wr_valid", s_if.wr_valid_o, 1);
    check("st8_wr_a", s_if.wr_addr_a_o, 1);
    sample_at(12);
    check("st12_stage", s_if.stage_o, 1);
    check("st12_rd_valid", s_if.rd_valid_o, 1);
    sample_at(29);
    check("st29_done", s_if.done_o, 0);
    check("st29_busy", s_if.busy_o, 1);
    sample_at(30);
    check("st30_done", s_if.done_o, 1);

    $display("[TB] start held high");
    apply_stimulus();
    nominal_checks(1'b1);
    sample_at(29);
    check("h29_busy", s_if.busy_o, 1);
    check("h29_rd_a", s_if.rd_addr_a_o, 0);
    check("h29_rd_valid", s_if.rd_valid_o, 1);
    drive_at(30);
    s_if.start_i = 1'b0;
    sample_at(56);
    check("h56_done", s_if.done_o, 1);
    sample_at(57);
    check("h_dones", s_ndone, 2);
    check("h_reads", s_nrd, 24);

    $display("[TB] reset mid-run");
    apply_stimulus();
    drive_at(1);
    s_if.start_i = 1'b0;
    sample_at(10);
    check("r10_stage", s_if.stage_o, 1);
    drive_at(12);
    rst_n = 1'b0;
    #1;
    check("r_busy", s_if.busy_o, 0);
    check("r_rd_valid", s_if.rd_valid_o, 0);
    check("r_wr_valid", s_if.wr_valid_o, 0);
    check("r_stage", s_if.stage_o, 0);
    check("r_rd_a", s_if.rd_addr_a_o, 0);
    check("r_rd_b", s_if.rd_addr_b_o, 0);
    for (int c = 13; c <= 17; c++) begin
      sample_at(c);
      check("r_no_wr", s_if.wr_valid_o, 0);
    end
    drive_at(18);
    rst_n = 1'b1;
    apply_stimulus();
    nominal_checks(1'b0);
    sample_at(29);
    check("rp_reads", s_nrd, 12);
    check("rp_writes", s_nwr, 12);

    $display("[TB] large transform, random enable");
    next_cycle();
    b_if.en_i    = 1'b1;
    b_if.start_i = 1'b1;
    next_cycle();
    b_if.start_i = 1'b0;
    b_seen = 1'b0;
    for (int i = 0; i < 50000 && !b_seen; i++) begin
      b_if.en_i = ($urandom_range(0, 7) != 0);
      next_cycle();
      if (b_if.done_o) b_seen = 1'b1;
    end
    check("b_done_seen", b_seen, 1);
    next_cycle();
    next_cycle();
    check("b_reads", b_nrd, B_LOGN * (B_N / 2));
    check("b_writes", b_nwr, B_LOGN * (B_N / 2));
    check("b_dones", b_ndone, 1);
    check("b_busy_end", b_if.busy_o, 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
